// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one external ALU between two requesters,
//               with operand capture, a fixed execute window and a held response.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_W      = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_i,
    input  logic [DATA_W-1:0] r0_src1_i,
    input  logic [DATA_W-1:0] r0_src2_i,
    input  logic [3:0]        r0_ctrl_i,
    input  logic [2:0]        r0_bonus_i,
    input  logic [DATA_W-1:0] r1_src1_i,
    input  logic [DATA_W-1:0] r1_src2_i,
    input  logic [3:0]        r1_ctrl_i,
    input  logic [2:0]        r1_bonus_i,
    output logic [1:0]        gnt_o,
    output logic              alu_rst_n_o,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [3:0]        alu_ctrl_o,
    output logic [2:0]        alu_bonus_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    input  logic              alu_cout_i,
    input  logic              alu_overflow_i,
    output logic              rsp_valid_o,
    output logic              rsp_id_o,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_zero_o,
    output logic              rsp_cout_o,
    output logic              rsp_ovf_o,
    input  logic              rsp_ready_i
);

    localparam int                 c_cnt_w    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_last_id;
    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_gnt;

    // Operand registers double as the ALU drive; cleared outside EXEC.
    logic [DATA_W-1:0]  r_src1;
    logic [DATA_W-1:0]  r_src2;
    logic [3:0]         r_ctrl;
    logic [2:0]         r_bonus;

    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [DATA_W-1:0]  r_rsp_result;
    logic               r_rsp_zero;
    logic               r_rsp_cout;
    logic               r_rsp_ovf;

    logic               w_winner;
    logic               w_start;
    logic               w_exec_done;
    logic               w_rsp_accept;

    always_comb begin
        w_winner     = 1'b0;
        w_start      = 1'b0;
        w_exec_done  = 1'b0;
        w_rsp_accept = 1'b0;
        w_state_nxt  = r_state;

        // With both requesting, the one not served last wins.
        case (req_i)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            2'b11:   w_winner = ~r_last_id;
            default: w_winner = 1'b0;
        endcase

        w_start      = (r_state == ST_IDLE) && (req_i != 2'b00);
        w_exec_done  = (r_state == ST_EXEC) && (r_cnt == c_cnt_last);
        w_rsp_accept = (r_state == ST_RESP) && rsp_ready_i;

        case (r_state)
            ST_IDLE: if (w_start)      w_state_nxt = ST_EXEC;
            ST_EXEC: if (w_exec_done)  w_state_nxt = ST_RESP;
            ST_RESP: if (w_rsp_accept) w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_id    <= 1'b1;
            r_cnt        <= '0;
            r_gnt        <= 2'b00;
            r_src1       <= '0;
            r_src2       <= '0;
            r_ctrl       <= '0;
            r_bonus      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_cout   <= 1'b0;
            r_rsp_ovf    <= 1'b0;
        end else begin
            r_gnt <= 2'b00;
            if (w_start) begin
                r_gnt     <= w_winner ? 2'b10 : 2'b01;
                r_last_id <= w_winner;
                r_cnt     <= '0;
                r_src1    <= w_winner ? r1_src1_i  : r0_src1_i;
                r_src2    <= w_winner ? r1_src2_i  : r0_src2_i;
                r_ctrl    <= w_winner ? r1_ctrl_i  : r0_ctrl_i;
                r_bonus   <= w_winner ? r1_bonus_i : r0_bonus_i;
            end else if (r_state == ST_EXEC) begin
                if (w_exec_done) begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_id     <= r_last_id;
                    r_rsp_result <= alu_result_i;
                    r_rsp_zero   <= alu_zero_i;
                    r_rsp_cout   <= alu_cout_i;
                    r_rsp_ovf    <= alu_overflow_i;
                    r_cnt        <= '0;
                    r_src1       <= '0;
                    r_src2       <= '0;
                    r_ctrl       <= '0;
                    r_bonus      <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_rsp_accept) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign gnt_o        = r_gnt;
    assign alu_rst_n_o  = ~rst_i;
    assign alu_src1_o   = r_src1;
    assign alu_src2_o   = r_src2;
    assign alu_ctrl_o   = r_ctrl;
    assign alu_bonus_o  = r_bonus;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_id_o     = r_rsp_id;
    assign rsp_result_o = r_rsp_result;
    assign rsp_zero_o   = r_rsp_zero;
    assign rsp_cout_o   = r_rsp_cout;
    assign rsp_ovf_o    = r_rsp_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Self-checking bench for alu_share_arbiter with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int E1 = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] r0_src1, r0_src2, r1_src1, r1_src2;
    logic [3:0]  r0_ctrl, r1_ctrl;
    logic [2:0]  r0_bonus, r1_bonus;
    logic        rsp_ready;

    logic [1:0]  gnt, gnt3;
    logic        alu_rst_n, alu_rst_n3;
    logic [31:0] alu_src1, alu_src2, alu3_src1, alu3_src2;
    logic [3:0]  alu_ctrl, alu3_ctrl;
    logic [2:0]  alu_bonus, alu3_bonus;
    logic [34:0] alu_out, alu3_out;
    logic        rsp_valid, rsp_id, rsp_zero, rsp_cout, rsp_ovf;
    logic        rsp3_valid, rsp3_id, rsp3_zero, rsp3_cout, rsp3_ovf;
    logic [31:0] rsp_result, rsp3_result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: returns {overflow, cout, zero, result}.
    function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c, input logic [2:0] bn);
        logic [32:0] s;
        logic [31:0] r;
        logic        co, ov;
        s = '0; r = '0; co = 1'b0; ov = 1'b0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0110: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; co = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0011: r = a * b;
            4'b0111: r = (bn == 3'b100) ? {31'd0, a == b} : {31'd0, $signed(a) < $signed(b)};
            default: r = '0;
        endcase
        return {ov, co, (r == 32'd0), r};
    endfunction

    assign alu_out  = alu_fn(alu_src1, alu_src2, alu_ctrl, alu_bonus);
    assign alu3_out = alu_fn(alu3_src1, alu3_src2, alu3_ctrl, alu3_bonus);

    alu_share_arbiter #(.DATA_W(32), .EXEC_CYCLES(E1)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .r0_src1_i(r0_src1), .r0_src2_i(r0_src2), .r0_ctrl_i(r0_ctrl), .r0_bonus_i(r0_bonus),
        .r1_src1_i(r1_src1), .r1_src2_i(r1_src2), .r1_ctrl_i(r1_ctrl), .r1_bonus_i(r1_bonus),
        .gnt_o(gnt), .alu_rst_n_o(alu_rst_n),
        .alu_src1_o(alu_src1), .alu_src2_o(alu_src2), .alu_ctrl_o(alu_ctrl), .alu_bonus_o(alu_bonus),
        .alu_result_i(alu_out[31:0]), .alu_zero_i(alu_out[32]), .alu_cout_i(alu_out[33]),
        .alu_overflow_i(alu_out[34]),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_result_o(rsp_result),
        .rsp_zero_o(rsp_zero), .rsp_cout_o(rsp_cout), .rsp_ovf_o(rsp_ovf), .rsp_ready_i(rsp_ready)
    );

    alu_share_arbiter #(.DATA_W(32), .EXEC_CYCLES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .r0_src1_i(r0_src1), .r0_src2_i(r0_src2), .r0_ctrl_i(r0_ctrl), .r0_bonus_i(r0_bonus),
        .r1_src1_i(r1_src1), .r1_src2_i(r1_src2), .r1_ctrl_i(r1_ctrl), .r1_bonus_i(r1_bonus),
        .gnt_o(gnt3), .alu_rst_n_o(alu_rst_n3),
        .alu_src1_o(alu3_src1), .alu_src2_o(alu3_src2), .alu_ctrl_o(alu3_ctrl), .alu_bonus_o(alu3_bonus),
        .alu_result_i(alu3_out[31:0]), .alu_zero_i(alu3_out[32]), .alu_cout_i(alu3_out[33]),
        .alu_overflow_i(alu3_out[34]),
        .rsp_valid_o(rsp3_valid), .rsp_id_o(rsp3_id), .rsp_result_o(rsp3_result),
        .rsp_zero_o(rsp3_zero), .rsp_cout_o(rsp3_cout), .rsp_ovf_o(rsp3_ovf), .rsp_ready_i(rsp_ready)
    );

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [2:0]  bonus;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] corners[5];
    logic [3:0]  ctrls[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 2'b00; rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input string nm, input logic [1:0] exp_g);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (gnt == 2'b00 && n < 20);
        chk(nm, {62'd0, gnt}, {62'd0, exp_g});
    endtask

    task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, input logic [2:0] bn);
        if (r == 0) begin
            r0_src1 = a; r0_src2 = b; r0_ctrl = c; r0_bonus = bn;
        end else begin
            r1_src1 = a; r1_src2 = b; r1_ctrl = c; r1_bonus = bn;
        end
    endtask

    function automatic logic [31:0] rand_opnd();
        if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
        return $urandom;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          busy;
        int          g;
        logic        last, win;
        logic [31:0] oa, ob;
        logic [3:0]  oc;
        logic [2:0]  obn;
        logic [1:0]  eg;
        logic [34:0] ex;
        bit          want[2];
        logic [31:0] qa[2], qb[2];
        logic [3:0]  qc[2];
        logic [2:0]  qbn[2];
        bit          in_exec, vld;

        corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        ctrls   = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011, 4'b0111};
        vecs[0] = '{2'b01, 32'd5,          32'd7,      4'b0010, 3'b000, 32'd12,         1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'b10, 32'h8000_0000, 32'd1,      4'b0110, 3'b000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{2'b01, 32'd9,          32'd9,      4'b0111, 3'b100, 32'd1,          1'b0, 1'b0, 1'b0};
        vecs[3] = '{2'b10, 32'hFFFF_FFFF, 32'd1,      4'b0010, 3'b000, 32'd0,          1'b1, 1'b1, 1'b0};
        vecs[4] = '{2'b01, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000, 3'b000, 32'h0000_F000, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{2'b10, 32'd3,          32'd3,      4'b0110, 3'b000, 32'd0,          1'b1, 1'b1, 1'b0};
        vecs[6] = '{2'b01, 32'h7FFF_FFFF, 32'd1,      4'b0010, 3'b000, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{2'b10, 32'hFFFF_FFFF, 32'd1,      4'b0111, 3'b000, 32'd1,          1'b0, 1'b0, 1'b0};

        set_op(0, 32'd0, 32'd0, 4'd0, 3'd0);
        set_op(1, 32'd0, 32'd0, 4'd0, 3'd0);

        // Reset state
        do_reset();
        rst = 1'b1;
        step();
        chk("rst_gnt", {62'd0, gnt}, 64'd0);
        chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_alu_src1", {32'd0, alu_src1}, 64'd0);
        chk("rst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
        chk("rst_alu_rst_n", {63'd0, alu_rst_n}, 64'd0);
        rst = 1'b0;
        #1;
        chk("run_alu_rst_n", {63'd0, alu_rst_n}, 64'd1);

        // Table-driven single transactions: latency, passthrough and flags
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int r;
            r = vecs[i].req[1] ? 1 : 0;
            set_op(r, vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].bonus);
            set_op(1 - r, ~vecs[i].a, ~vecs[i].b, 4'b0001, 3'b111);
            req = vecs[i].req;
            step();
            chk($sformatf("v%0d_gnt", i), {62'd0, gnt}, {62'd0, vecs[i].req});
            chk($sformatf("v%0d_alu_src1", i), {32'd0, alu_src1}, {32'd0, vecs[i].a});
            chk($sformatf("v%0d_alu_src2", i), {32'd0, alu_src2}, {32'd0, vecs[i].b});
            chk($sformatf("v%0d_alu_ctl", i), {57'd0, alu_ctrl, alu_bonus},
                {57'd0, vecs[i].ctrl, vecs[i].bonus});
            req = 2'b00;
            step();
            chk($sformatf("v%0d_valid", i), {63'd0, rsp_valid}, 64'd1);
            chk($sformatf("v%0d_id", i), {63'd0, rsp_id}, {63'd0, vecs[i].req[1]});
            chk($sformatf("v%0d_result", i), {32'd0, rsp_result}, {32'd0, vecs[i].res});
            chk($sformatf("v%0d_flags", i), {61'd0, rsp_zero, rsp_cout, rsp_ovf},
                {61'd0, vecs[i].z, vecs[i].c, vecs[i].v});
            chk($sformatf("v%0d_gnt_off", i), {62'd0, gnt}, 64'd0);
            chk($sformatf("v%0d_alu_idle", i), {32'd0, alu_src1}, 64'd0);
            step();
            chk($sformatf("v%0d_valid_drop", i), {63'd0, rsp_valid}, 64'd0);
        end

        // Round-robin alternation after reset
        do_reset();
        rsp_ready = 1'b1;
        set_op(0, 32'd1, 32'd2, 4'b0010, 3'b000);
        set_op(1, 32'd3, 32'd4, 4'b0010, 3'b000);
        req = 2'b11;
        step();
        chk("alt_first", {62'd0, gnt}, 64'd1);
        req = 2'b10;
        wait_gnt("alt_second", 2'b10);
        req = 2'b00;
        step(); step(); step();
        req = 2'b11;
        wait_gnt("alt_third", 2'b01);
        req = 2'b00;
        step(); step(); step();

        // Response held under back-pressure, pending request waits for handshake
        do_reset();
        set_op(0, 32'd5, 32'd7, 4'b0010, 3'b000);
        set_op(1, 32'h8000_0000, 32'd1, 4'b0110, 3'b000);
        req = 2'b01;
        step();
        chk("bp_gnt0", {62'd0, gnt}, 64'd1);
        req = 2'b10;
        step();
        chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp_hold_valid%0d", i), {63'd0, rsp_valid}, 64'd1);
            chk($sformatf("bp_hold_result%0d", i), {32'd0, rsp_result}, 64'd12);
            chk($sformatf("bp_hold_id%0d", i), {63'd0, rsp_id}, 64'd0);
            chk($sformatf("bp_no_gnt%0d", i), {62'd0, gnt}, 64'd0);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_accept_valid", {63'd0, rsp_valid}, 64'd0);
        chk("bp_accept_gnt", {62'd0, gnt}, 64'd0);
        step();
        chk("bp_gnt1", {62'd0, gnt}, 64'd2);
        req = 2'b00;
        step();
        chk("bp_r1_result", {32'd0, rsp_result}, 64'h7FFF_FFFF);
        chk("bp_r1_ovf", {63'd0, rsp_ovf}, 64'd1);
        chk("bp_r1_id", {63'd0, rsp_id}, 64'd1);
        step();

        // Three-cycle execute window on the MUL instance
        do_reset();
        rsp_ready = 1'b1;
        set_op(0, 32'd6, 32'd7, 4'b0011, 3'b000);
        req = 2'b01;
        step();
        chk("mul_gnt", {62'd0, gnt3}, 64'd1);
        req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            chk($sformatf("mul_src_c%0d", i), {alu3_src1, alu3_src2}, {32'd6, 32'd7});
            chk($sformatf("mul_ctrl_c%0d", i), {60'd0, alu3_ctrl}, 64'd3);
            chk($sformatf("mul_novalid_c%0d", i), {63'd0, rsp3_valid}, 64'd0);
        end
        step();
        chk("mul_valid", {63'd0, rsp3_valid}, 64'd1);
        chk("mul_result", {32'd0, rsp3_result}, 64'd42);
        chk("mul_alu_idle", {32'd0, alu3_src1}, 64'd0);
        step();
        chk("mul_valid_drop", {63'd0, rsp3_valid}, 64'd0);

        // Reset during the execute window discards the operation
        do_reset();
        rsp_ready = 1'b1;
        set_op(0, 32'd5, 32'd7, 4'b0010, 3'b000);
        req = 2'b01;
        step();
        chk("mid_gnt", {62'd0, gnt}, 64'd1);
        chk("mid_gnt3", {62'd0, gnt3}, 64'd1);
        req = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_gnt", {60'd0, gnt, gnt3}, 64'd0);
        chk("mid_rst_valid", {62'd0, rsp_valid, rsp3_valid}, 64'd0);
        chk("mid_rst_alu", {alu_src1, alu3_src1}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("mid_no_rsp%0d", i), {62'd0, rsp_valid, rsp3_valid}, 64'd0);
        end

        // Randomized traffic against a transaction-timing reference model
        do_reset();
        busy = 1'b0; g = 0; last = 1'b1;
        oa = '0; ob = '0; oc = '0; obn = '0;
        want[0] = 1'b0; want[1] = 1'b0;
        for (int r = 0; r < 2; r++) begin
            qa[r] = '0; qb[r] = '0; qc[r] = '0; qbn[r] = '0;
        end
        for (int k = 0; k < 1500; k++) begin
            req = {want[1], want[0]};
            set_op(0, qa[0], qb[0], qc[0], qbn[0]);
            set_op(1, qa[1], qb[1], qc[1], qbn[1]);
            rsp_ready = ($urandom_range(3) != 0);
            @(posedge clk);
            eg = 2'b00;
            if (!busy) begin
                if (req != 2'b00) begin
                    win = (req == 2'b11) ? ~last : req[1];
                    oa = win ? qa[1] : qa[0];
                    ob = win ? qb[1] : qb[0];
                    oc = win ? qc[1] : qc[0];
                    obn = win ? qbn[1] : qbn[0];
                    busy = 1'b1; g = k; last = win;
                    eg = win ? 2'b10 : 2'b01;
                end
            end else if (k >= g + E1 + 1 && rsp_ready) begin
                busy = 1'b0;
            end
            #1;
            in_exec = busy && (k >= g) && (k <= g + E1 - 1);
            vld     = busy && (k >= g + E1);
            chk("rnd_gnt", {62'd0, gnt}, {62'd0, eg});
            chk("rnd_alu_src", {alu_src1, alu_src2}, in_exec ? {oa, ob} : 64'd0);
            chk("rnd_alu_ctl", {57'd0, alu_ctrl, alu_bonus}, in_exec ? {57'd0, oc, obn} : 64'd0);
            chk("rnd_valid", {63'd0, rsp_valid}, {63'd0, vld});
            if (vld) begin
                ex = alu_fn(oa, ob, oc, obn);
                chk("rnd_id", {63'd0, rsp_id}, {63'd0, last});
                chk("rnd_result", {32'd0, rsp_result}, {32'd0, ex[31:0]});
                chk("rnd_flags", {61'd0, rsp_ovf, rsp_cout, rsp_zero}, {61'd0, ex[34:32]});
            end
            for (int r = 0; r < 2; r++) begin
                if (eg[r]) begin
                    want[r] = 1'b0;
                end else if (!want[r] && $urandom_range(2) == 0) begin
                    want[r] = 1'b1;
                    qa[r]   = rand_opnd();
                    qb[r]   = rand_opnd();
                    qc[r]   = ctrls[$urandom_range(5)];
                    qbn[r]  = 3'($urandom_range(7));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
